// File: rtl/ahb_lite_simple_master.sv
// Single-outstanding-pipeline AHB-Lite master: one address-phase stage (A) and one
// data-phase stage (D), with two-cycle ERROR handling and cancellation of the queued request.
module ahb_lite_simple_master #(
  parameter int HADDR_WIDTH = 32,
  parameter int HDATA_WIDTH = 32
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [HADDR_WIDTH-1:0] req_addr,
  input  logic                   req_write,
  input  logic [2:0]             req_size,
  input  logic [HDATA_WIDTH-1:0] req_wdata,
  output logic                   rsp_valid,
  output logic [HDATA_WIDTH-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic [HADDR_WIDTH-1:0] HADDR,
  output logic [2:0]             HSIZE,
  output logic                   HWRITE,
  output logic [1:0]             HTRANS,
  output logic [2:0]             HBURST,
  output logic                   HMASTLOCK,
  output logic [3:0]             HPROT,
  output logic [HDATA_WIDTH-1:0] HWDATA,
  input  logic                   HREADY,
  input  logic [HDATA_WIDTH-1:0] HRDATA,
  input  logic                   HRESP
);

  typedef enum logic {
    ST_RUN,
    ST_ERR1
  } err_state_e;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_NONSEQ = 2'b10
  } htrans_e;

  err_state_e             err_state_q, err_state_d;
  logic                   a_valid_q, a_valid_d;
  logic [HDATA_WIDTH-1:0] a_wdata_q, a_wdata_d;
  logic [HADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic [2:0]             hsize_q, hsize_d;
  logic                   hwrite_q, hwrite_d;
  logic                   d_valid_q, d_valid_d;
  logic                   d_write_q, d_write_d;
  logic [HDATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic                   cancel_q, cancel_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [HDATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    err_state_d = err_state_q;
    a_valid_d   = a_valid_q;
    a_wdata_d   = a_wdata_q;
    haddr_d     = haddr_q;
    hsize_d     = hsize_q;
    hwrite_d    = hwrite_q;
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    hwdata_d    = hwdata_q;
    cancel_d    = cancel_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    if (err_state_q == ST_ERR1) begin
      // A was already flushed on the first error cycle, so D simply empties here.
      if (HREADY) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        d_valid_d   = 1'b0;
        d_write_d   = 1'b0;
        err_state_d = ST_RUN;
      end
    end else begin
      // A pending cancel is reported one cycle after the erroring transfer; D is
      // guaranteed empty then, so it never competes with a normal completion.
      if (cancel_q) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        cancel_d    = 1'b0;
      end else if (HREADY && d_valid_q) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = HRESP;
        if (!d_write_q && !HRESP) begin
          rsp_rdata_d = HRDATA;
        end
      end

      if (HREADY) begin
        d_valid_d = a_valid_q;
        d_write_d = a_valid_q && hwrite_q;
        if (a_valid_q && hwrite_q) begin
          hwdata_d = a_wdata_q;
        end
        a_valid_d = req_valid;
        if (req_valid) begin
          haddr_d   = req_addr;
          hsize_d   = req_size;
          hwrite_d  = req_write;
          a_wdata_d = req_wdata;
        end
      end else if (d_valid_q && HRESP) begin
        err_state_d = ST_ERR1;
        cancel_d    = a_valid_q;
        a_valid_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_state_q <= ST_RUN;
      a_valid_q   <= 1'b0;
      a_wdata_q   <= '0;
      haddr_q     <= '0;
      hsize_q     <= '0;
      hwrite_q    <= 1'b0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      hwdata_q    <= '0;
      cancel_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      err_state_q <= err_state_d;
      a_valid_q   <= a_valid_d;
      a_wdata_q   <= a_wdata_d;
      haddr_q     <= haddr_d;
      hsize_q     <= hsize_d;
      hwrite_q    <= hwrite_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      hwdata_q    <= hwdata_d;
      cancel_q    <= cancel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = HREADY && (err_state_q != ST_ERR1);
  assign HTRANS    = a_valid_q ? TRANS_NONSEQ : TRANS_IDLE;
  assign HADDR     = haddr_q;
  assign HSIZE     = hsize_q;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = hwdata_q;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = 4'b0011;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_lite_simple_master.sv
// Scoreboard bench for ahb_lite_simple_master: transaction-level expectation model,
// reactive AHB slave model, and an independent response monitor.
module tb_ahb_lite_simple_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          req_write = 1'b0;
  logic [2:0]    req_size = 3'd0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] HADDR;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [1:0]    HTRANS;
  logic [2:0]    HBURST;
  logic          HMASTLOCK;
  logic [3:0]    HPROT;
  logic [DW-1:0] HWDATA;
  logic          HREADY = 1'b1;
  logic [DW-1:0] HRDATA = '0;
  logic          HRESP = 1'b0;

  ahb_lite_simple_master #(.HADDR_WIDTH(AW), .HDATA_WIDTH(DW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HSIZE(HSIZE), .HWRITE(HWRITE), .HTRANS(HTRANS),
    .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;
  int n_edge   = 0;
  int ready_cnt = 0;
  int max_wait = 0;

  always @(posedge HCLK) begin
    n_edge <= n_edge + 1;
    if (HREADY) ready_cnt <= ready_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave behaviour, keyed by address so the expectation model can predict it.
  function automatic logic is_err(input logic [31:0] a);
    return (a == 32'h10) || (a[6:4] == 3'b111);
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h13579BDF);
  endfunction

  function automatic logic [31:0] wd(input logic [31:0] a);
    if (a == 32'h0) return 32'h11;
    if (a == 32'h4) return 32'h22;
    return ~a ^ 32'h2468ACE0;
  endfunction

  function automatic int nwait(input logic [31:0] a);
    if (a == 32'h8) return 2;
    return (max_wait == 0) ? 0 : int'($urandom_range(0, max_wait));
  endfunction

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;
  exp_t sb[$];

  // Expectation model state: a request is cancelled when the previously accepted
  // request failed on the bus and this one was accepted on the very next ready edge.
  int prev_idx = -10;
  bit prev_errbus = 1'b0;

  task automatic issue(input logic [31:0] a, input logic w, input int lat);
    int   waited;
    bit   ok;
    int   idx;
    bit   b2b, canc, eb;
    exp_t e;
    waited = 0;
    ok = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    req_size  = 3'd2;
    req_wdata = w ? wd(a) : $urandom;
    while (!ok && waited < 200) begin
      @(negedge HCLK);
      if (req_ready) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      check("req_accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    idx  = ready_cnt + 1;
    b2b  = (idx == prev_idx + 1);
    canc = prev_errbus && b2b;
    eb   = is_err(a) && !canc;
    e.err   = canc || eb;
    e.rdata = (e.err || w) ? 32'h0 : rd(a);
    e.due   = (lat < 0) ? -1 : (n_edge + 1 + lat);
    sb.push_back(e);
    prev_idx    = idx;
    prev_errbus = eb;
    @(posedge HCLK);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge HCLK);
      #1;
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge HCLK);
    #1;
  endtask

  // Response monitor
  exp_t mon_e;
  always @(negedge HCLK) begin
    if (HRESETn && rsp_valid) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
        check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
        if (mon_e.due >= 0) check("rsp_latency", 64'(n_edge), 64'(mon_e.due));
      end
    end
  end

  // Reactive slave: samples bus at negedge, updates its drive 1 time unit after posedge.
  logic        s_hready, s_hwrite;
  logic [1:0]  s_htrans;
  logic [31:0] s_haddr, s_hwdata;
  bit          dp_active = 1'b0, dp_write, dp_err, dp_err2;
  logic [31:0] dp_addr;
  int          dp_wait;

  always @(negedge HCLK) begin
    s_hready = HREADY;
    s_htrans = HTRANS;
    s_haddr  = HADDR;
    s_hwrite = HWRITE;
    s_hwdata = HWDATA;
  end

  initial begin
    forever begin
      @(posedge HCLK);
      #1;
      if (!HRESETn) begin
        dp_active = 1'b0;
      end else if (s_hready) begin
        if (dp_active && !dp_err && dp_write) check("hwdata", 64'(s_hwdata), 64'(wd(dp_addr)));
        dp_active = (s_htrans == 2'b10);
        if (dp_active) begin
          dp_addr  = s_haddr;
          dp_write = s_hwrite;
          dp_wait  = nwait(s_haddr);
          dp_err   = is_err(s_haddr);
          dp_err2  = 1'b0;
        end
      end else if (dp_active) begin
        if (dp_wait > 0) dp_wait--;
        else if (dp_err) dp_err2 = 1'b1;
      end
      if (!HRESETn || !dp_active) begin
        HREADY = 1'b1;
        HRESP  = HRESETn ? 1'($urandom_range(0, 1)) : 1'b0;
        HRDATA = $urandom;
      end else if (dp_wait > 0) begin
        HREADY = 1'b0;
        HRESP  = 1'b0;
        HRDATA = $urandom;
      end else if (!dp_err) begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = dp_write ? $urandom : rd(dp_addr);
      end else begin
        HREADY = dp_err2;
        HRESP  = 1'b1;
        HRDATA = $urandom;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] ra;
  logic        rw;

  initial begin
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_htrans", 64'(HTRANS), 64'd0);
    check("rst_haddr", 64'(HADDR), 64'd0);
    check("rst_hsize", 64'(HSIZE), 64'd0);
    check("rst_hwrite", 64'(HWRITE), 64'd0);
    check("rst_hwdata", 64'(HWDATA), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("hburst", 64'(HBURST), 64'd0);
    check("hprot", 64'(HPROT), 64'h3);
    check("hmastlock", 64'(HMASTLOCK), 64'd0);
    @(negedge HCLK);
    #2 HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Single zero-wait read
    issue(32'h100, 1'b0, 2);
    check("rd_htrans", 64'(HTRANS), 64'h2);
    check("rd_haddr", 64'(HADDR), 64'h100);
    check("rd_hsize", 64'(HSIZE), 64'd2);
    check("rd_hwrite", 64'(HWRITE), 64'd0);
    drain();

    // Back-to-back writes: next address phase overlaps previous data phase
    issue(32'h0, 1'b1, 2);
    issue(32'h4, 1'b1, 2);
    check("b2b_haddr", 64'(HADDR), 64'h4);
    check("b2b_htrans", 64'(HTRANS), 64'h2);
    check("b2b_hwdata0", 64'(HWDATA), 64'h11);
    @(posedge HCLK);
    #1;
    check("b2b_hwdata1", 64'(HWDATA), 64'h22);
    drain();

    // Wait states with a queued request held in the address phase
    issue(32'h8, 1'b0, 4);
    issue(32'hC, 1'b0, 4);
    for (int i = 0; i < 2; i++) begin
      check("wait_req_ready", 64'(req_ready), 64'd0);
      check("wait_haddr", 64'(HADDR), 64'hC);
      check("wait_htrans", 64'(HTRANS), 64'h2);
      @(posedge HCLK);
      #1;
    end
    drain();

    // Error on 0x10 cancels the queued 0x14
    issue(32'h10, 1'b0, 3);
    issue(32'h14, 1'b0, 3);
    @(posedge HCLK);
    #1;
    check("err2_htrans", 64'(HTRANS), 64'd0);
    check("err2_req_ready", 64'(req_ready), 64'd0);
    drain();

    // Reset during a data phase drops the transfer
    issue(32'h20, 1'b0, -1);
    @(posedge HCLK);
    #3;
    HRESETn = 1'b0;
    sb.delete();
    prev_errbus = 1'b0;
    #1;
    check("mid_rst_htrans", 64'(HTRANS), 64'd0);
    check("mid_rst_haddr", 64'(HADDR), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    #2 HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    issue(32'h24, 1'b0, 2);
    drain();

    // Randomized traffic with wait states, errors and idle gaps
    max_wait = 2;
    for (int i = 0; i < 300; i++) begin
      ra = 32'($urandom_range(0, 1023)) << 2;
      rw = 1'($urandom_range(0, 1));
      issue(ra, rw, -1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge HCLK);
        #1;
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
